// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, four BCD digits out.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (4'hF) on a normal result.
module bin2bcd_seq #(
    parameter int NUM_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Start,
    input  logic [NUM_WIDTH-1:0] Number,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Overflow,
    output logic [3:0]           Digit0,
    output logic [3:0]           Digit1,
    output logic [3:0]           Digit2,
    output logic [3:0]           Digit3,
    output logic [1:0]           StateDbg
);

    // Handshake: a request is accepted on a rising Clk edge where Ready=1 and Start=1; Number is
    // sampled on that edge only. Start is ignored otherwise and never queued. Done pulses one cycle
    // when Digit0..3/Overflow have just been updated; no acknowledge is expected.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_SHIFT = 5'(NUM_WIDTH - 1);

    state_t               state;
    state_t               stateNext;
    logic [NUM_WIDTH-1:0] binReg;
    logic [19:0]          bcdReg;
    logic [19:0]          bcdNext;
    logic [4:0]           shiftCnt;
    logic                 ovfReg;
    logic                 accept;
    logic                 lastShift;
    logic [15:0]          digitsLoad;

    // Add 3 to each nibble >= 5, then shift the next binary bit into the low end.
    function automatic logic [19:0] shiftBcd(input logic [19:0] bcd, input logic inBit);
        logic [19:0] adj;
        logic [3:0]  nib;
        adj = '0;
        for (int i = 0; i < 5; i++) begin
            nib = bcd[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            adj[4*i +: 4] = nib;
        end
        return {adj[18:0], inBit};
    endfunction

    assign accept    = (state == IDLE) && Start;
    assign lastShift = (shiftCnt == LAST_SHIFT);
    assign bcdNext   = shiftBcd(bcdReg, binReg[NUM_WIDTH-1]);
    assign StateDbg  = state;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        Ready     = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                Ready = 1'b1;
                if (Start) begin
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                Busy = 1'b1;
                if (lastShift) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                Done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Value presented on the digit outputs at the end of the final shift.
    always_comb begin
        digitsLoad = bcdNext[15:0];
        if (ovfReg) begin
            digitsLoad = 16'hFFFF;
        end
`ifdef LEADING_ZERO_BLANK_EN
        else if (bcdNext[15:12] == 4'h0) begin
            digitsLoad[15:12] = 4'hF;
            if (bcdNext[11:8] == 4'h0) begin
                digitsLoad[11:8] = 4'hF;
                if (bcdNext[7:4] == 4'h0) begin
                    digitsLoad[7:4] = 4'hF;
                end
            end
        end
`endif
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            binReg   <= '0;
            bcdReg   <= '0;
            shiftCnt <= '0;
            ovfReg   <= 1'b0;
            Overflow <= 1'b0;
            Digit0   <= 4'h0;
            Digit1   <= 4'h0;
            Digit2   <= 4'h0;
            Digit3   <= 4'h0;
        end else if (accept) begin
            binReg   <= Number;
            bcdReg   <= '0;
            shiftCnt <= '0;
            ovfReg   <= (32'(Number) >= 32'd10000);
        end else if (state == SHIFT) begin
            bcdReg   <= bcdNext;
            binReg   <= binReg << 1;
            shiftCnt <= shiftCnt + 5'd1;
            if (lastShift) begin
                Overflow <= ovfReg;
                Digit3   <= digitsLoad[15:12];
                Digit2   <= digitsLoad[11:8];
                Digit1   <= digitsLoad[7:4];
                Digit0   <= digitsLoad[3:0];
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: 16-bit and 8-bit instances, expected-result queues checked on each Done.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        start16, start8;
    logic [15:0] number16;
    logic [7:0]  number8;
    logic        ready16, busy16, done16, ovf16;
    logic        ready8, busy8, done8, ovf8;
    logic [3:0]  d16[4];
    logic [3:0]  d8[4];
    logic [1:0]  state16, state8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [16:0] expQ16[$];
    logic [16:0] expQ8[$];
    logic [16:0] e16, e8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.NUM_WIDTH(16)) dut16 (
        .Clk(clk), .Rst_n(rstN), .Start(start16), .Number(number16),
        .Ready(ready16), .Busy(busy16), .Done(done16), .Overflow(ovf16),
        .Digit0(d16[0]), .Digit1(d16[1]), .Digit2(d16[2]), .Digit3(d16[3]),
        .StateDbg(state16)
    );

    bin2bcd_seq #(.NUM_WIDTH(8)) dut8 (
        .Clk(clk), .Rst_n(rstN), .Start(start8), .Number(number8),
        .Ready(ready8), .Busy(busy8), .Done(done8), .Overflow(ovf8),
        .Digit0(d8[0]), .Digit1(d8[1]), .Digit2(d8[2]), .Digit3(d8[3]),
        .StateDbg(state8)
    );

    // Expected {overflow, Digit3..Digit0} computed by decimal division.
    function automatic logic [16:0] model(input int value);
        int          d[4];
        logic [15:0] dg;
        if (value >= 10000) return {1'b1, 16'hFFFF};
        d[0] = value % 10;
        d[1] = (value / 10) % 10;
        d[2] = (value / 100) % 10;
        d[3] = value / 1000;
        dg = {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
`ifdef LEADING_ZERO_BLANK_EN
        if (d[3] == 0) begin
            dg[15:12] = 4'hF;
            if (d[2] == 0) begin
                dg[11:8] = 4'hF;
                if (d[1] == 0) dg[7:4] = 4'hF;
            end
        end
`endif
        return {1'b0, dg};
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every Done pops one expected result.
    always @(negedge clk) begin
        if (done16) begin
            if (expQ16.size() == 0) begin
                checkValue("unexpected_done16", 32'd1, 32'd0);
            end else begin
                e16 = expQ16.pop_front();
                checkValue("digits16", {16'h0, d16[3], d16[2], d16[1], d16[0]}, {16'h0, e16[15:0]});
                checkValue("overflow16", {31'h0, ovf16}, {31'h0, e16[16]});
            end
        end
        if (done8) begin
            if (expQ8.size() == 0) begin
                checkValue("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e8 = expQ8.pop_front();
                checkValue("digits8", {16'h0, d8[3], d8[2], d8[1], d8[0]}, {16'h0, e8[15:0]});
                checkValue("overflow8", {31'h0, ovf8}, {31'h0, e8[16]});
            end
        end
    end

    task automatic runConv(input bit use8, input int value);
        int k;
        int lat;
        k = 0;
        @(negedge clk);
        while (!(use8 ? ready8 : ready16) && k < 50) begin
            @(negedge clk);
            k++;
        end
        checkValue("ready_before_start", {31'h0, (use8 ? ready8 : ready16)}, 32'd1);
        if (use8) begin
            start8  = 1'b1;
            number8 = 8'(value);
            expQ8.push_back(model(value));
        end else begin
            start16  = 1'b1;
            number16 = 16'(value);
            expQ16.push_back(model(value));
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start16 = 1'b0;
        lat = 0;
        while (!(use8 ? done8 : done16) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkValue(use8 ? "latency8" : "latency16", lat, use8 ? 32'd8 : 32'd16);
        @(posedge clk);
        #1;
        checkValue("ready_after_done", {31'h0, (use8 ? ready8 : ready16)}, 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((expQ16.size() != 0 || expQ8.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkValue("drain", expQ16.size() + expQ8.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int k;
        int acceptCyc[2];
        int vals[2];

        start16  = 1'b0;
        start8   = 1'b0;
        number16 = '0;
        number8  = '0;
        #1 rstN = 1'b0;
        #11;
        checkValue("rst_ready", {31'h0, ready16}, 32'd1);
        checkValue("rst_busy", {31'h0, busy16}, 32'd0);
        checkValue("rst_done", {31'h0, done16}, 32'd0);
        checkValue("rst_ovf", {31'h0, ovf16}, 32'd0);
        checkValue("rst_digits16", {16'h0, d16[3], d16[2], d16[1], d16[0]}, 32'd0);
        checkValue("rst_digits8", {16'h0, d8[3], d8[2], d8[1], d8[0]}, 32'd0);
        checkValue("rst_state", {30'h0, state16}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        runConv(0, 1234);
        runConv(0, 0);
        runConv(0, 9999);
        runConv(0, 10000);
        runConv(0, 65535);
        runConv(0, 7);

        // Start held high while Number wanders; only IDLE cycles may accept.
        vals[0] = 777;
        vals[1] = 42;
        acc = 0;
        k = 0;
        acceptCyc[0] = 0;
        acceptCyc[1] = 0;
        @(negedge clk);
        start16 = 1'b1;
        while (acc < 2 && k < 80) begin
            if (ready16) begin
                number16 = 16'(vals[acc]);
                expQ16.push_back(model(vals[acc]));
                acceptCyc[acc] = cyc;
                acc++;
            end else begin
                number16 = 16'($urandom_range(0, 65535));
            end
            @(negedge clk);
            k++;
        end
        start16 = 1'b0;
        checkValue("held_accepts", acc, 32'd2);
        checkValue("held_spacing", acceptCyc[1] - acceptCyc[0], 32'd18);
        drain();

        // Reset in the middle of a conversion.
        runConv(0, 1234);
        @(negedge clk);
        start16  = 1'b1;
        number16 = 16'd5555;
        expQ16.push_back(model(5555));
        @(posedge clk);
        #1 start16 = 1'b0;
        repeat (5) @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        checkValue("abort_digits", {16'h0, d16[3], d16[2], d16[1], d16[0]}, 32'd0);
        checkValue("abort_ovf", {31'h0, ovf16}, 32'd0);
        checkValue("abort_ready", {31'h0, ready16}, 32'd1);
        checkValue("abort_busy", {31'h0, busy16}, 32'd0);
        checkValue("abort_state", {30'h0, state16}, 32'd0);
        void'(expQ16.pop_back());
        @(negedge clk);
        rstN = 1'b1;
        repeat (25) @(negedge clk);
        checkValue("post_abort_digits", {16'h0, d16[3], d16[2], d16[1], d16[0]}, 32'd0);
        checkValue("post_abort_ready", {31'h0, ready16}, 32'd1);
        runConv(0, 5555);

        // Narrow instance.
        runConv(1, 255);
        runConv(1, 0);
        runConv(1, 99);
        for (int i = 0; i < 3; i++) runConv(1, int'($urandom_range(0, 255)));
        for (int i = 0; i < 5; i++) runConv(0, int'($urandom_range(0, 65535)));
        runConv(0, 1005);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
